spi_frame_master: RTL and testbench

Host-side SPI master that drives the fixed 264-bit framed protocol used by our FPGA peripherals' SPI slave port. Each accepted 32-bit command word (byte0 = opcode, bytes 1–3 = payload) is shifted out LSB-first on MOSI. The full 264-bit MISO frame is captured and split into a status byte and a 256-bit data word. It sits in the controlling FPGA/SoC between a command-issuing FSM and the SPI pins.

---
 rtl/spi_frame_master.sv | 130 +++++++++++++
 tb/tb_spi_frame_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// SPI master for the fixed 264-bit peripheral frame: a 32-bit command goes out LSB-first on MOSI,
// and the 264-bit MISO frame is captured and split into a status byte and a 256-bit data word.
module spi_frame_master #(
   parameter int CLK_DIV    = 4,
   parameter int FRAME_BITS = 264
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [31:0]  cmd_data,
   output logic         rsp_valid,
   output logic [7:0]   rsp_status,
   output logic         rsp_ack,
   output logic         rsp_has_data,
   output logic [255:0] rsp_data,
   output logic         SPI_SCK,
   output logic         SPI_SS,
   output logic         SPI_MOSI,
   input  logic         SPI_MISO
);

   localparam int CNT_W = $clog2(2 * CLK_DIV);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SCK_HI, S_SCK_LO, S_HOLD, S_GAP
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        w_len;
   logic                    w_last;
   logic                    w_hs;
   logic [8:0]              r_bit;
   logic [31:0]             r_shift;
   logic [FRAME_BITS-2:0]   r_cap;
   logic                    r_miso_s1;
   logic                    r_miso_s2;
   logic                    r_rsp_valid;
   logic [7:0]              r_status;
   logic [255:0]            r_data;

   // GAP lasts two half-periods; every other timed state lasts one.
   assign w_len  = (r_state == S_GAP) ? CNT_W'(2 * CLK_DIV - 1) : CNT_W'(CLK_DIV - 1);
   assign w_last = (r_cnt == w_len);
   assign w_hs   = cmd_valid && (r_state == S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (cmd_valid) w_next = S_SETUP;
         S_SETUP:  if (w_last) w_next = S_SCK_HI;
         // The last falling edge goes straight to HOLD instead of a final SCK_LO.
         S_SCK_HI: if (w_last) w_next = (r_bit == 9'(FRAME_BITS - 1)) ? S_HOLD : S_SCK_LO;
         S_SCK_LO: if (w_last) w_next = S_SCK_HI;
         S_HOLD:   if (w_last) w_next = S_GAP;
         S_GAP:    if (w_last) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      SPI_SS    = 1'b1;
      SPI_SCK   = 1'b0;
      SPI_MOSI  = 1'b0;
      case (r_state)
         S_IDLE:   cmd_ready = 1'b1;
         S_SETUP,
         S_SCK_LO: begin
            SPI_SS   = 1'b0;
            SPI_MOSI = r_shift[0];
         end
         S_SCK_HI: begin
            SPI_SS   = 1'b0;
            SPI_SCK  = 1'b1;
            SPI_MOSI = r_shift[0];
         end
         S_HOLD:   SPI_SS = 1'b0;
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || (w_next != r_state)) r_cnt <= '0;
      else                              r_cnt <= r_cnt + CNT_W'(1);
   end

   // Shifting on the HI->LO transition presents the next command bit at the falling edge.
   always_ff @(posedge clk) begin
      r_miso_s1 <= SPI_MISO;
      r_miso_s2 <= r_miso_s1;
      if (w_hs) begin
         r_shift <= cmd_data;
         r_bit   <= '0;
      end else if ((r_state == S_SCK_HI) && w_last) begin
         r_shift <= {1'b0, r_shift[31:1]};
         if (r_bit < 9'(FRAME_BITS - 1)) r_cap[r_bit] <= r_miso_s2;
      end else if ((r_state == S_SCK_LO) && w_last) begin
         r_bit <= r_bit + 9'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_status    <= '0;
         r_data      <= '0;
      end else begin
         r_rsp_valid <= (r_state == S_HOLD) && w_last;
         if ((r_state == S_HOLD) && w_last) begin
            r_status <= r_cap[7:0];
            r_data   <= r_cap[FRAME_BITS-2:7];
         end
      end
   end

   assign rsp_valid    = r_rsp_valid;
   assign rsp_status   = r_status;
   assign rsp_ack      = r_status[5];
   assign rsp_has_data = r_status[6];
   assign rsp_data     = r_data;

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: D=4 instance for protocol scenarios, D=7 instance for timing scaling.
module tb_spi_frame_master;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic         cmd_valid = 1'b0;
   logic [31:0]  cmd_data = '0;
   logic         cmd_ready, rsp_valid, rsp_ack, rsp_has_data;
   logic [7:0]   rsp_status;
   logic [255:0] rsp_data;
   logic         sck, ss, mosi;
   logic         miso = 1'b0;

   logic         cmd_valid7 = 1'b0;
   logic [31:0]  cmd_data7 = '0;
   logic         cmd_ready7, rsp_valid7, rsp_ack7, rsp_has_data7;
   logic [7:0]   rsp_status7;
   logic [255:0] rsp_data7;
   logic         sck7, ss7, mosi7;
   logic         miso7 = 1'b0;

   spi_frame_master #(.CLK_DIV(4)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_ack(rsp_ack), .rsp_has_data(rsp_has_data),
      .rsp_data(rsp_data), .SPI_SCK(sck), .SPI_SS(ss), .SPI_MOSI(mosi), .SPI_MISO(miso)
   );

   spi_frame_master #(.CLK_DIV(7)) dut7 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid7), .cmd_ready(cmd_ready7), .cmd_data(cmd_data7),
      .rsp_valid(rsp_valid7), .rsp_status(rsp_status7), .rsp_ack(rsp_ack7), .rsp_has_data(rsp_has_data7),
      .rsp_data(rsp_data7), .SPI_SCK(sck7), .SPI_SS(ss7), .SPI_MOSI(mosi7), .SPI_MISO(miso7)
   );

   // Behavioural slaves: sample MOSI and present frame bit k on rising edge k.
   logic [263:0] sl_frame = '0;
   int           sl_k = 0;
   int           sl_hi = 0;
   logic [31:0]  sl_rx = '0;
   int           sl_k7 = 0;

   always @(posedge sck or ss) begin
      if (ss) miso = 1'b0;
      else if (!sck) begin
         sl_k = 0; sl_rx = '0; sl_hi = 0;
      end else begin
         if (sl_k < 32) sl_rx[sl_k] = mosi;
         else if (mosi) sl_hi++;
         if (sl_k < 264) miso = sl_frame[sl_k];
         sl_k++;
      end
   end

   always @(posedge sck7 or ss7) begin
      if (ss7) miso7 = 1'b0;
      else if (!sck7) sl_k7 = 0;
      else begin
         if (sl_k7 < 264) miso7 = sl_frame[sl_k7];
         sl_k7++;
      end
   end

   int   cyc = 0;
   int   t_hs = 0, hs_prev = 0, t_rise0 = 0, t_fall = 0, t_rv = 0;
   int   n_rise = 0, ss_low = 0, ready_busy = 0, hi_run = 0, last_gap = 0;
   logic p_sck = 1'b0, p_ss = 1'b1;
   int   t_hs7 = 0, t_rise07 = 0, t_fall7 = 0, t_rv7 = 0, n_rise7 = 0, ss_low7 = 0;
   logic p_sck7 = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (cmd_valid && cmd_ready) begin
         hs_prev = t_hs; t_hs = cyc; n_rise = 0; ss_low = 0; ready_busy = 0;
      end
      if (sck && !p_sck) begin
         if (n_rise == 0) t_rise0 = cyc;
         n_rise++;
      end
      if (!sck && p_sck) t_fall = cyc;
      if (!ss) begin
         ss_low++;
         if (cmd_ready) ready_busy++;
         if (p_ss) last_gap = hi_run;
         hi_run = 0;
      end else hi_run++;
      if (rsp_valid) t_rv = cyc;
      p_sck = sck; p_ss = ss;

      if (cmd_valid7 && cmd_ready7) begin
         t_hs7 = cyc; n_rise7 = 0; ss_low7 = 0;
      end
      if (sck7 && !p_sck7) begin
         if (n_rise7 == 0) t_rise07 = cyc;
         n_rise7++;
      end
      if (!sck7 && p_sck7) t_fall7 = cyc;
      if (!ss7) ss_low7++;
      if (rsp_valid7) t_rv7 = cyc;
      p_sck7 = sck7;
   end

   function automatic logic [263:0] mk_frame(input logic has, input logic [255:0] d);
      logic [263:0] f;
      f = '0;
      f[262:7] = d;
      f[5] = 1'b1;
      f[6] = has;
      return f;
   endfunction

   task automatic send(input logic [31:0] w);
      int n;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_data = w;
      n = 0;
      do begin @(negedge clk); n++; end while (!cmd_ready && n < 5000);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL send_handshake: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, n); end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 5000);
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, expected 1", rsp_valid, n); end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
      checks++; if (ss !== 1'b1) begin errors++; $display("FAIL reset_ss: got %b expected 1", ss); end
      checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", sck); end
      checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (rsp_status !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", rsp_status); end
      checks++; if (rsp_data !== 256'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", rsp_data); end
   endtask

   task automatic test_init_frame();
      sl_frame = mk_frame(1'b0, 256'h0);
      send(32'h0000_0001);
      wait_rsp();
      checks++; if (t_rise0 - t_hs !== 5) begin errors++; $display("FAIL init_rise0: got T+%0d expected T+5", t_rise0 - t_hs); end
      checks++; if (t_fall - t_hs !== 2113) begin errors++; $display("FAIL init_lastfall: got T+%0d expected T+2113", t_fall - t_hs); end
      checks++; if (t_rv - t_hs !== 2117) begin errors++; $display("FAIL init_rsp_time: got T+%0d expected T+2117", t_rv - t_hs); end
      checks++; if (n_rise !== 264) begin errors++; $display("FAIL init_sck_rises: got %0d expected 264", n_rise); end
      checks++; if (ss_low !== 2116) begin errors++; $display("FAIL init_ss_low: got %0d expected 2116", ss_low); end
      checks++; if (ready_busy !== 0) begin errors++; $display("FAIL init_ready_busy: got %0d expected 0", ready_busy); end
      checks++; if (sl_rx !== 32'h0000_0001) begin errors++; $display("FAIL init_mosi_word: got %h expected 00000001", sl_rx); end
      checks++; if (sl_hi !== 0) begin errors++; $display("FAIL init_mosi_tail: got %0d ones expected 0", sl_hi); end
      checks++; if (rsp_status !== 8'h20) begin errors++; $display("FAIL init_status: got %h expected 20", rsp_status); end
      checks++; if (rsp_ack !== 1'b1) begin errors++; $display("FAIL init_ack: got %b expected 1", rsp_ack); end
      checks++; if (rsp_has_data !== 1'b0) begin errors++; $display("FAIL init_has_data: got %b expected 0", rsp_has_data); end
   endtask

   task automatic test_data_return();
      sl_frame = mk_frame(1'b1, 256'hcafe77);
      send(32'h0000_0012);
      wait_rsp();
      checks++; if (rsp_status[6:5] !== 2'b11) begin errors++; $display("FAIL data_status65: got %b expected 11", rsp_status[6:5]); end
      checks++; if (rsp_status !== 8'hE0) begin errors++; $display("FAIL data_status: got %h expected e0", rsp_status); end
      checks++; if (rsp_data !== 256'hcafe77) begin errors++; $display("FAIL data_word: got %h expected cafe77", rsp_data); end
      @(negedge clk);
      checks++; if (rsp_data !== 256'hcafe77) begin errors++; $display("FAIL data_hold: got %h expected cafe77", rsp_data); end
      sl_frame = mk_frame(1'b0, 256'h0);
      send(32'h0000_0013);
      wait_rsp();
      checks++; if (rsp_has_data !== 1'b0) begin errors++; $display("FAIL nodata_flag: got %b expected 0", rsp_has_data); end
      checks++; if (rsp_data !== 256'h0) begin errors++; $display("FAIL nodata_word: got %h expected 0", rsp_data); end
   endtask

   task automatic test_payload();
      sl_frame = mk_frame(1'b0, 256'h0);
      send(32'hA5C3_3C02);
      wait_rsp();
      checks++; if (sl_rx !== 32'hA5C3_3C02) begin errors++; $display("FAIL payload_word: got %h expected a5c33c02", sl_rx); end
      checks++; if (sl_hi !== 0) begin errors++; $display("FAIL payload_tail: got %0d ones expected 0", sl_hi); end
   endtask

   task automatic test_back_to_back();
      int n;
      sl_frame = mk_frame(1'b0, 256'h0);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_data = 32'h0F0F_1234;
      n = 0;
      do begin @(negedge clk); n++; end while (!cmd_ready && n < 5000);
      @(posedge clk); #1;
      cmd_data = 32'h8000_0001;
      wait_rsp();
      checks++; if (ready_busy !== 0) begin errors++; $display("FAIL b2b_ready_busy: got %0d expected 0", ready_busy); end
      checks++; if (sl_rx !== 32'h0F0F_1234) begin errors++; $display("FAIL b2b_word1: got %h expected 0f0f1234", sl_rx); end
      n = 0;
      do begin @(negedge clk); n++; end while (!cmd_ready && n < 5000);
      #1;
      checks++; if (t_hs - hs_prev !== 2125) begin errors++; $display("FAIL b2b_period: got %0d expected 2125", t_hs - hs_prev); end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_rsp();
      checks++; if (last_gap !== 9) begin errors++; $display("FAIL b2b_ss_gap: got %0d expected 9", last_gap); end
      checks++; if (sl_rx !== 32'h8000_0001) begin errors++; $display("FAIL b2b_word2: got %h expected 80000001", sl_rx); end
   endtask

   task automatic test_reset_mid();
      int n;
      int nrv;
      sl_frame = mk_frame(1'b1, 256'hdead_beef);
      send(32'h0000_0055);
      n = 0;
      do begin @(negedge clk); n++; end while (!(sck && sl_k == 101) && n < 5000);
      checks++; if (sl_k !== 101) begin errors++; $display("FAIL mid_edge100: slave count %0d expected 101", sl_k); end
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (ss !== 1'b1) begin errors++; $display("FAIL mid_ss: got %b expected 1", ss); end
      checks++; if (sck !== 1'b0) begin errors++; $display("FAIL mid_sck: got %b expected 0", sck); end
      checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL mid_mosi: got %b expected 0", mosi); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", cmd_ready); end
      nrv = 0;
      repeat (2200) begin @(negedge clk); if (rsp_valid) nrv++; end
      checks++; if (nrv !== 0) begin errors++; $display("FAIL mid_no_rsp: got %0d pulses expected 0", nrv); end
      checks++; if (rsp_status !== 8'h00) begin errors++; $display("FAIL mid_status_cleared: got %h expected 00", rsp_status); end
      sl_frame = mk_frame(1'b1, 256'h1234_5678);
      send(32'h0000_0003);
      wait_rsp();
      checks++; if (rsp_data !== 256'h1234_5678) begin errors++; $display("FAIL mid_after_data: got %h expected 12345678", rsp_data); end
      checks++; if (rsp_status !== 8'h60) begin errors++; $display("FAIL mid_after_status: got %h expected 60", rsp_status); end
   endtask

   task automatic test_clkdiv7();
      int n;
      sl_frame = mk_frame(1'b1, 256'hcafe77);
      @(posedge clk); #1;
      cmd_valid7 = 1'b1; cmd_data7 = 32'h0000_0001;
      n = 0;
      do begin @(negedge clk); n++; end while (!cmd_ready7 && n < 5000);
      @(posedge clk); #1;
      cmd_valid7 = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid7 && n < 8000);
      #1;
      checks++; if (rsp_valid7 !== 1'b1) begin errors++; $display("FAIL d7_timeout: rsp_valid=%b expected 1", rsp_valid7); end
      checks++; if (t_rise07 - t_hs7 !== 8) begin errors++; $display("FAIL d7_rise0: got T+%0d expected T+8", t_rise07 - t_hs7); end
      checks++; if (t_fall7 - t_hs7 !== 3697) begin errors++; $display("FAIL d7_lastfall: got T+%0d expected T+3697", t_fall7 - t_hs7); end
      checks++; if (t_rv7 - t_hs7 !== 3704) begin errors++; $display("FAIL d7_rsp_time: got T+%0d expected T+3704", t_rv7 - t_hs7); end
      checks++; if (n_rise7 !== 264) begin errors++; $display("FAIL d7_sck_rises: got %0d expected 264", n_rise7); end
      checks++; if (ss_low7 !== 3703) begin errors++; $display("FAIL d7_ss_low: got %0d expected 3703", ss_low7); end
      checks++; if (rsp_data7 !== 256'hcafe77) begin errors++; $display("FAIL d7_data: got %h expected cafe77", rsp_data7); end
      checks++; if (rsp_status7 !== 8'hE0) begin errors++; $display("FAIL d7_status: got %h expected e0", rsp_status7); end
   endtask

   initial begin
      test_reset();
      test_init_frame();
      test_data_return();
      test_payload();
      test_back_to_back();
      test_reset_mid();
      test_clkdiv7();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
